crash_event_scheduler: RTL and testbench

- Collects per-pixel border crash levels (charCrashLeft/Right, arrowCrash, bubbleCrash) across one VGA frame into sticky flags.
- At startOfFrame, snapshots the flags and delivers each pending crash, one at a time, to the object movement logic over a single valid/ready event port.
- Movement logic therefore sees each crash at most once per frame, never at pixel rate.
- Sits between border_crash and the char/arrow/bubble move blocks.

---
 rtl/crash_event_scheduler.sv | 111 +++++++++++
 tb/tb_crash_event_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crash_event_scheduler.sv
// Per-frame border crash collector and one-at-a-time event dispatcher.
// Optional drop-on-timeout for unacknowledged events: define CRASH_TIMEOUT_EN.
module crash_event_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       charCrashLeft,
    input  logic       charCrashRight,
    input  logic       arrowCrash,
    input  logic       bubbleCrash,
    input  logic       evtReady,
    output logic       evtValid,
    output logic [1:0] evtId,
    output logic       dispatchDone,
    output logic       overrun,
    output logic       dropped
);

    typedef enum logic {IDLE, DISPATCH} state_t;

    state_t     state;
    logic [3:0] sticky;
    logic [3:0] pending;
    logic [3:0] crashIn;
    logic [3:0] clrMask;
    logic [3:0] pendAfter;
    logic [3:0] pendNext;
    logic [1:0] nextId;
    logic       xfer;
    logic       drop;

    if (TIMEOUT_CYCLES < 2) begin : gParamChk
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    function automatic logic [1:0] lowestBit(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else if (v[3]) return 2'd3;
        else           return 2'd0;
    endfunction

    // A dropped event is retired exactly like an accepted one.
    always_comb begin
        crashIn   = {bubbleCrash, arrowCrash, charCrashRight, charCrashLeft};
        xfer      = evtValid && evtReady;
        clrMask   = (xfer || drop) ? (4'(1) << evtId) : 4'b0000;
        pendAfter = pending & ~clrMask;
        pendNext  = startOfFrame ? (pendAfter | sticky) : pendAfter;
        nextId    = lowestBit(pendNext);
    end

`ifdef CRASH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

    logic [CntW-1:0] tmoCnt;

    assign drop = evtValid && !evtReady
               && (tmoCnt == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign drop    = 1'b0;
    assign dropped = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sticky       <= '0;
            pending      <= '0;
            evtValid     <= 1'b0;
            evtId        <= '0;
            dispatchDone <= 1'b0;
            overrun      <= 1'b0;
`ifdef CRASH_TIMEOUT_EN
            tmoCnt       <= '0;
            dropped      <= 1'b0;
`endif
        end else begin
            // Crashes seen in the snapshot cycle belong to the next frame.
            if (startOfFrame) begin
                sticky <= crashIn;
                if (pendAfter != 4'b0000)
                    overrun <= 1'b1;
            end else begin
                sticky <= sticky | crashIn;
            end

            pending  <= pendNext;
            evtValid <= (pendNext != 4'b0000);
            evtId    <= nextId;
            state    <= (pendNext != 4'b0000) ? DISPATCH : IDLE;

            dispatchDone <= (pendNext == 4'b0000)
                         && ((state == DISPATCH) || startOfFrame);

`ifdef CRASH_TIMEOUT_EN
            if (drop)
                dropped <= 1'b1;
            // Wait time restarts on any transfer, drop or change of event.
            if (evtValid && !evtReady && !drop && (nextId == evtId))
                tmoCnt <= tmoCnt + 1'b1;
            else
                tmoCnt <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_crash_event_scheduler.sv
// Scoreboard bench for crash_event_scheduler: expected event ids are queued
// as crashes are driven and retired as the DUT hands them over.
module tb_crash_event_scheduler;

`ifdef CRASH_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 1024;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       charCrashLeft = 1'b0;
    logic       charCrashRight = 1'b0;
    logic       arrowCrash = 1'b0;
    logic       bubbleCrash = 1'b0;
    logic       evtReady = 1'b0;
    logic       evtValid;
    logic [1:0] evtId;
    logic       dispatchDone;
    logic       overrun;
    logic       dropped;

    int total = 0;
    int bad = 0;
    int doneCnt = 0;
    int base;
    logic [1:0] expQ[$];

    crash_event_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .reset(reset),
        .startOfFrame(startOfFrame),
        .charCrashLeft(charCrashLeft),
        .charCrashRight(charCrashRight),
        .arrowCrash(arrowCrash),
        .bubbleCrash(bubbleCrash),
        .evtReady(evtReady),
        .evtValid(evtValid),
        .evtId(evtId),
        .dispatchDone(dispatchDone),
        .overrun(overrun),
        .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs are stable from posedge+1, so negedge sees what the next edge sees.
    always @(negedge clk) begin
        if (!reset) begin
            if (evtValid && evtReady) begin
                if (expQ.size() == 0)
                    chk("unexpected_evt", int'(evtId) + 10, 0);
                else
                    chk("evtId_order", int'(evtId), int'(expQ.pop_front()));
            end
            if (dispatchDone)
                doneCnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setCrash(input logic [3:0] v);
        {bubbleCrash, arrowCrash, charCrashRight, charCrashLeft} = v;
    endtask

    task automatic pulse(input logic [3:0] v, input int n);
        setCrash(v);
        repeat (n) step();
        setCrash(4'b0000);
        step();
    endtask

    task automatic sof(input logic [3:0] v);
        setCrash(v);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        setCrash(4'b0000);
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!dispatchDone && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, int'(dispatchDone), 1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        @(negedge clk);
        chk("rst_valid", int'(evtValid), 0);
        chk("rst_id", int'(evtId), 0);
        chk("rst_done", int'(dispatchDone), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_dropped", int'(dropped), 0);
        step();
        reset = 1'b0;
        step();

        // Single crash, ready held
        evtReady = 1'b1;
        pulse(4'b0001, 3);
        expQ.push_back(2'd0);
        sof(4'b0000);
        @(negedge clk);
        chk("single_valid_n1", int'(evtValid), 1);
        chk("single_id_n1", int'(evtId), 0);
        step();
        @(negedge clk);
        chk("single_done_n2", int'(dispatchDone), 1);
        chk("single_valid_n2", int'(evtValid), 0);
        step();
        @(negedge clk);
        chk("single_done_once", int'(dispatchDone), 0);
        chk("single_q_empty", expQ.size(), 0);
        step();

        // All four with backpressure
        evtReady = 1'b0;
        pulse(4'b1111, 1);
        expQ.push_back(2'd0);
        expQ.push_back(2'd1);
        expQ.push_back(2'd2);
        expQ.push_back(2'd3);
        sof(4'b0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(evtValid), 1);
            chk("bp_id_hold", int'(evtId), 0);
            step();
        end
        base = doneCnt;
        evtReady = 1'b1;
        waitDone("four_done");
        step();
        chk("four_q_empty", expQ.size(), 0);
        chk("four_done_count", doneCnt - base, 1);

        // Empty frame
        sof(4'b0000);
        @(negedge clk);
        chk("empty_done_n1", int'(dispatchDone), 1);
        chk("empty_valid", int'(evtValid), 0);
        step();

        // Crash in the snapshot cycle goes to the next frame
        sof(4'b0100);
        @(negedge clk);
        chk("late_valid", int'(evtValid), 0);
        chk("late_done", int'(dispatchDone), 1);
        step();
        step();
        expQ.push_back(2'd2);
        sof(4'b0000);
        @(negedge clk);
        chk("late_next_valid", int'(evtValid), 1);
        chk("late_next_id", int'(evtId), 2);
        step();
        step();
        chk("late_q_empty", expQ.size(), 0);

        // Overrun and priority re-evaluation
        evtReady = 1'b0;
        base = doneCnt;
        pulse(4'b1000, 1);
        sof(4'b0000);
        @(negedge clk);
        chk("ovr_id_bubble", int'(evtId), 3);
        chk("ovr_not_yet", int'(overrun), 0);
        step();
        pulse(4'b0010, 2);
        sof(4'b0000);
        @(negedge clk);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_id_switch", int'(evtId), 1);
        step();
        expQ.push_back(2'd1);
        expQ.push_back(2'd3);
        evtReady = 1'b1;
        waitDone("ovr_done");
        step();
        chk("ovr_q_empty", expQ.size(), 0);
        chk("ovr_done_count", doneCnt - base, 1);
        chk("ovr_sticky", int'(overrun), 1);

        // Reset mid-dispatch with pending 1010
        evtReady = 1'b0;
        pulse(4'b1010, 1);
        sof(4'b0000);
        @(negedge clk);
        chk("rmd_id", int'(evtId), 1);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("rmd_valid", int'(evtValid), 0);
        chk("rmd_overrun", int'(overrun), 0);
        step();
        reset = 1'b0;
        evtReady = 1'b1;
        step();
        base = doneCnt;
        sof(4'b0000);
        @(negedge clk);
        chk("rmd_empty_done", int'(dispatchDone), 1);
        chk("rmd_empty_valid", int'(evtValid), 0);
        repeat (4) step();
        chk("rmd_done_count", doneCnt - base, 1);
        chk("rmd_q_empty", expQ.size(), 0);

`ifdef CRASH_TIMEOUT_EN
        begin
            int n;
            evtReady = 1'b0;
            pulse(4'b0100, 1);
            sof(4'b0000);
            n = 0;
            @(negedge clk);
            while (evtValid && n < 30) begin
                n++;
                @(negedge clk);
            end
            chk("tmo_len", n, 8);
            chk("tmo_done", int'(dispatchDone), 1);
            chk("tmo_dropped", int'(dropped), 1);
            step();
        end
`else
        chk("no_tmo_dropped", int'(dropped), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
